// File: rtl/axil_rd_engine_if.sv
// AXI4-Lite read engine bus: user request/response and AR/R channels.
// The master modport is the engine side, the slave modport the environment.
interface axil_rd_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic                  i_rd_valid;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  o_rd_ready;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic [1:0]            o_rd_resp;
  logic                  i_rd_ready;
  logic [ADDR_WIDTH-1:0] o_araddr;
  logic [2:0]            o_arprot;
  logic                  o_arvalid;
  logic                  i_arready;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic [1:0]            i_rresp;
  logic                  i_rvalid;
  logic                  o_rready;

  modport master (
    input  i_rd_valid, i_rd_addr, i_rd_ready,
    input  i_arready, i_rdata, i_rresp, i_rvalid,
    output o_rd_ready, o_rd_valid, o_rd_data, o_rd_resp,
    output o_araddr, o_arprot, o_arvalid, o_rready
  );

  modport slave (
    output i_rd_valid, i_rd_addr, i_rd_ready,
    output i_arready, i_rdata, i_rresp, i_rvalid,
    input  o_rd_ready, o_rd_valid, o_rd_data, o_rd_resp,
    input  o_araddr, o_arprot, o_arvalid, o_rready
  );
endinterface

// File: rtl/axil_rd_engine.sv
// Credit-limited AXI4-Lite read master with in-order response FIFO.
// Optional response watchdog: define AXIL_RD_TIMEOUT_EN.
module axil_rd_engine #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic aenable,
  input  logic i_err_clr,
  output logic o_busy,
  output logic o_rd_err,
  output logic o_timeout,
  axil_rd_engine_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

  if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("axil_rd_engine: illegal parameter value");
  end

  logic [CW-1:0] credits;
  logic          accept;
  logic          pop;
  logic          r_hs;
  logic          rready_q;

  assign bus.o_rd_ready = aenable && !areset &&
                          (credits < MAXC) &&
                          (!bus.o_arvalid || bus.i_arready);
  assign accept = bus.i_rd_valid && bus.o_rd_ready;
  assign pop    = bus.o_rd_valid && bus.i_rd_ready;
  assign r_hs   = bus.i_rvalid && rready_q;
  assign o_busy = (credits != '0);
  assign bus.o_rready = rready_q;
  assign bus.o_arprot = 3'b000;

  always_ff @(posedge aclk) begin
    if (areset) begin
      credits <= '0;
    end else if (accept && !pop) begin
      credits <= credits + 1'b1;
    end else if (pop && !accept) begin
      credits <= credits - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.o_arvalid <= 1'b0;
      bus.o_araddr  <= '0;
      rready_q      <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (accept) begin
        bus.o_arvalid <= 1'b1;
        bus.o_araddr  <= bus.i_rd_addr;
      end else if (bus.i_arready) begin
        bus.o_arvalid <= 1'b0;
      end
    end
  end

  // Output head register plus backing store; credits bound total fill.
  logic [EW-1:0]         mem [MAX_OUTSTANDING];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         cnt;
  logic                  hv;
  logic [DATA_WIDTH-1:0] hd;
  logic [1:0]            hr;
  logic [DATA_WIDTH-1:0] rdata_m;
  logic [EW-1:0]         wdata;
  logic                  head_free;
  logic                  take;
  logic                  to_head;
  logic                  to_mem;

  assign rdata_m   = (bus.i_rresp == 2'b00) ? bus.i_rdata : '1;
  assign wdata     = {rdata_m, bus.i_rresp};
  assign head_free = !hv || pop;
  assign take      = head_free && (cnt != '0);
  assign to_head   = head_free && (cnt == '0) && r_hs;
  assign to_mem    = r_hs && !to_head;

  assign bus.o_rd_valid = hv;
  assign bus.o_rd_data  = hd;
  assign bus.o_rd_resp  = hr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge aclk) begin
    if (to_mem) mem[wptr] <= wdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (to_mem) wptr <= nxt(wptr);
      if (take)   rptr <= nxt(rptr);
      case ({to_mem, take})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      hv <= 1'b0;
      hd <= '0;
      hr <= '0;
    end else if (take) begin
      hv       <= 1'b1;
      {hd, hr} <= mem[rptr];
    end else if (to_head) begin
      hv       <= 1'b1;
      {hd, hr} <= wdata;
    end else if (pop) begin
      hv <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      o_rd_err <= 1'b0;
    end else if (r_hs && bus.i_rresp != 2'b00) begin
      o_rd_err <= 1'b1;
    end else if (i_err_clr) begin
      o_rd_err <= 1'b0;
    end
  end

`ifdef AXIL_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic          ar_hs;
  logic [CW-1:0] inflight;
  logic [TW-1:0] wd;
  logic          to_q;

  assign ar_hs     = bus.o_arvalid && bus.i_arready;
  assign o_timeout = to_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Watchdog saturates at the limit so the flag fires once per stall.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd   <= '0;
      to_q <= 1'b0;
    end else begin
      if (r_hs || inflight == '0) begin
        wd <= '0;
      end else if (wd != TMAX) begin
        wd <= wd + 1'b1;
      end
      if (!r_hs && inflight != '0 && wd == TMAX - 1'b1) begin
        to_q <= 1'b1;
      end else if (i_err_clr) begin
        to_q <= 1'b0;
      end
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_rd_engine.sv
// Scoreboard bench for axil_rd_engine with a queued AXI-Lite slave model.
// Timeout checks follow AXIL_RD_TIMEOUT_EN.
module tb_axil_rd_engine;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int TO = 16;

  logic aclk = 1'b0;
  logic areset;
  logic aenable;
  logic i_err_clr;
  logic o_busy;
  logic o_rd_err;
  logic o_timeout;

  axil_rd_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_rd_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset), .aenable(aenable),
    .i_err_clr(i_err_clr), .o_busy(o_busy),
    .o_rd_err(o_rd_err), .o_timeout(o_timeout),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  logic [DW+1:0] exp_q [$];
  logic [AW-1:0] ar_q [$];
  bit r_en = 1'b1;
  bit ar_rdy_en = 1'b1;

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    if (a == 16'h0040) return 64'h1122334455667788;
    return {a, ~a, a ^ 16'h5a5a, a + 16'h0123};
  endfunction

  function automatic logic [1:0] rsp(input logic [AW-1:0] a);
    return (a[11:8] == 4'hE) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [DW+1:0] expv(input logic [AW-1:0] a);
    if (rsp(a) != 2'b00) return {{DW{1'b1}}, rsp(a)};
    return {dat(a), 2'b00};
  endfunction

  task automatic check(input string tag,
                       input logic [DW+1:0] act,
                       input logic [DW+1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Slave: AR accepted into a queue, R answered in order when r_en.
  initial begin
    bit arf, rf, sr;
    logic [AW-1:0] a;
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.i_rresp   = '0;
    forever begin
      @(negedge aclk);
      arf = bus.o_arvalid && bus.i_arready;
      rf  = bus.i_rvalid && bus.o_rready;
      a   = bus.o_araddr;
      sr  = areset;
      @(posedge aclk);
      #2;
      if (sr) begin
        ar_q.delete();
        bus.i_rvalid = 1'b0;
        bus.i_arready = 1'b0;
      end else begin
        if (rf) void'(ar_q.pop_front());
        if (arf) ar_q.push_back(a);
        bus.i_arready = ar_rdy_en;
        if (r_en && ar_q.size() > 0) begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = dat(ar_q[0]);
          bus.i_rresp  = rsp(ar_q[0]);
        end else begin
          bus.i_rvalid = 1'b0;
        end
      end
    end
  end

  always @(negedge aclk) begin
    logic [DW+1:0] e;
    if (bus.i_rd_valid && bus.o_rd_ready)
      exp_q.push_back(expv(bus.i_rd_addr));
    if (bus.o_rd_valid && bus.i_rd_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp", {bus.o_rd_data, bus.o_rd_resp}, e);
      end
    end
  end

  task automatic send(input logic [AW-1:0] a);
    bit ok = 1'b0;
    bus.i_rd_valid = 1'b1;
    bus.i_rd_addr  = a;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (bus.o_rd_ready) ok = 1'b1;
      tick();
      if (ok) break;
    end
    bus.i_rd_valid = 1'b0;
    if (!ok) check("send_stuck", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    bus.i_rd_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (!o_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("drain", ok, 1);
  endtask

  initial begin
    int k;
    bit seen;
    areset = 1'b1;
    aenable = 1'b1;
    i_err_clr = 1'b0;
    bus.i_rd_valid = 1'b0;
    bus.i_rd_addr = '0;
    bus.i_rd_ready = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    check("rst_arvalid", bus.o_arvalid, 0);
    check("rst_araddr", bus.o_araddr, 0);
    check("rst_arprot", bus.o_arprot, 0);
    check("rst_rready", bus.o_rready, 0);
    check("rst_rd_valid", bus.o_rd_valid, 0);
    check("rst_rd_data", bus.o_rd_data, 0);
    check("rst_rd_resp", bus.o_rd_resp, 0);
    check("rst_rd_ready", bus.o_rd_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_rd_err, 0);
    check("rst_timeout", o_timeout, 0);
    tick();
    areset = 1'b0;
    tick();
    @(negedge aclk);
    check("rready_on", bus.o_rready, 1);

    // Enable gating
    tick();
    aenable = 1'b0;
    bus.i_rd_valid = 1'b1;
    bus.i_rd_addr = 16'h0040;
    @(negedge aclk);
    check("enable_off", bus.o_rd_ready, 0);

    // Single read, exact latency
    tick();
    aenable = 1'b1;
    bus.i_rd_ready = 1'b1;
    @(negedge aclk);
    check("single_ready", bus.o_rd_ready, 1);
    tick();
    bus.i_rd_valid = 1'b0;
    @(negedge aclk);
    check("single_arvalid", bus.o_arvalid, 1);
    check("single_araddr", bus.o_araddr, 16'h0040);
    check("single_arprot", bus.o_arprot, 0);
    tick();
    tick();
    @(negedge aclk);
    check("single_valid", bus.o_rd_valid, 1);
    check("single_data", bus.o_rd_data, 64'h1122334455667788);
    check("single_resp", bus.o_rd_resp, 0);
    wait_idle();

    // Credit limit
    tick();
    bus.i_rd_ready = 1'b0;
    k = 0;
    bus.i_rd_valid = 1'b1;
    bus.i_rd_addr = 16'h1000;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (bus.o_rd_ready) k++;
      tick();
      bus.i_rd_addr = 16'h1000 + 16'(k * 8);
    end
    @(negedge aclk);
    check("credit_accepts", k, MO);
    check("credit_ready", bus.o_rd_ready, 0);
    check("credit_busy", o_busy, 1);
    check("credit_fifo", bus.o_rd_valid, 1);
    tick();
    bus.i_rd_ready = 1'b1;
    @(negedge aclk);
    check("credit_pop_cyc", bus.o_rd_ready, 0);
    tick();
    bus.i_rd_ready = 1'b0;
    @(negedge aclk);
    check("credit_fifth", bus.o_rd_ready, 1);
    tick();
    bus.i_rd_valid = 1'b0;
    wait_idle();

    // AR backpressure
    tick();
    ar_rdy_en = 1'b0;
    bus.i_rd_valid = 1'b1;
    bus.i_rd_addr = 16'h2000;
    @(negedge aclk);
    check("bp_first_ready", bus.o_rd_ready, 1);
    tick();
    bus.i_rd_addr = 16'h2008;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("bp_arvalid", bus.o_arvalid, 1);
      check("bp_araddr", bus.o_araddr, 16'h2000);
      check("bp_ready", bus.o_rd_ready, 0);
      tick();
    end
    ar_rdy_en = 1'b1;
    @(negedge aclk);
    check("bp_same_cyc", bus.o_rd_ready, 1);
    tick();
    bus.i_rd_valid = 1'b0;
    @(negedge aclk);
    check("bp_next_addr", bus.o_araddr, 16'h2008);
    check("bp_next_valid", bus.o_arvalid, 1);
    wait_idle();

    // SLVERR on the middle read
    tick();
    check("err_pre", o_rd_err, 0);
    send(16'h0100);
    send(16'h0E08);
    send(16'h0110);
    wait_idle();
    check("err_set", o_rd_err, 1);
    repeat (3) tick();
    @(negedge aclk);
    check("err_sticky", o_rd_err, 1);
    tick();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    @(negedge aclk);
    check("err_clr", o_rd_err, 0);

    // Watchdog
    tick();
    r_en = 1'b0;
    send(16'h0200);
`ifdef AXIL_RD_TIMEOUT_EN
    tick();
    repeat (12) tick();
    @(negedge aclk);
    check("to_early", o_timeout, 0);
    tick();
    i_err_clr = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (o_timeout) seen = 1'b1;
      tick();
    end
    i_err_clr = 1'b0;
    check("to_set_wins", seen, 1);
    r_en = 1'b1;
    wait_idle();
    tick();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    @(negedge aclk);
    check("to_clr", o_timeout, 0);
`else
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge aclk);
      if (o_timeout) seen = 1'b1;
      tick();
    end
    check("to_absent", seen, 0);
    r_en = 1'b1;
    wait_idle();
`endif

    // Reset mid-operation
    tick();
    r_en = 1'b0;
    send(16'h0300);
    send(16'h0308);
    send(16'h0310);
    @(negedge aclk);
    check("mid_busy", o_busy, 1);
    tick();
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_ready", bus.o_rd_ready, 0);
    tick();
    areset = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    check("mid_arvalid", bus.o_arvalid, 0);
    check("mid_araddr", bus.o_araddr, 0);
    check("mid_rd_valid", bus.o_rd_valid, 0);
    check("mid_rd_data", bus.o_rd_data, 0);
    check("mid_busy0", o_busy, 0);
    check("mid_rready", bus.o_rready, 0);
    tick();
    r_en = 1'b1;
    tick();
    send(16'h0320);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=done", total);
    $fatal(1, "bench stuck");
  end

endmodule
